// File: rtl/uart_rx_frontend_if.sv
// Handshake bundle between the UART rx front end and its environment:
// line/config inputs and the per-frame result that feeds the rx FIFO.
interface uart_rx_frontend_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 en_i;
  logic [DIV_WIDTH-1:0] baud_div_i;
  logic [3:0]           data_size_i;
  logic                 parity_en_i;
  logic                 parity_odd_i;
  logic [1:0]           stop_size_i;
  logic                 rx_i;
  logic [8:0]           data_o;
  logic                 valid_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 break_o;
  logic                 busy_o;

  modport slave (
    input  en_i, baud_div_i, data_size_i, parity_en_i, parity_odd_i, stop_size_i, rx_i,
    output data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );

  modport master (
    output en_i, baud_div_i, data_size_i, parity_en_i, parity_odd_i, stop_size_i, rx_i,
    input  data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: rx sync, tick generator, start validation,
// 2-of-3 bit voting and frame assembly with parity/stop/break flags.
module uart_rx_frontend #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  uart_rx_frontend_if.slave bus
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_S0   = OSW'(M - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(M);
  localparam logic [OSW-1:0] OS_VOTE = OSW'(M + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [1:0]           r_sync;
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  state_t               r_state;
  logic [OSW-1:0]       r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_s0, r_s1;
  logic [8:0]           r_data_sr;
  logic                 r_par_bit;
  logic                 r_stop_idx;
  logic [3:0]           r_size;
  logic                 r_par_en, r_par_odd, r_two_stop;
  logic [8:0]           r_data;
  logic                 r_valid, r_perr, r_ferr, r_brk;

  logic       w_rx_s, w_tick, w_vote, w_vote_tick, w_bit_end, w_par_err;
  logic [3:0] w_size;

  assign w_rx_s      = r_sync[1];
  assign w_tick      = bus.en_i && (r_tick_cnt == bus.baud_div_i);
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_vote_tick = w_tick && (r_os_cnt == OS_VOTE);
  assign w_bit_end   = w_tick && (r_os_cnt == OS_LAST);
  assign w_par_err   = r_par_en && ((^r_data_sr ^ r_par_bit) != r_par_odd);
  assign w_size      = (bus.data_size_i < 4'd6) ? 4'd6 :
                       (bus.data_size_i > 4'd9) ? 4'd9 : bus.data_size_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], bus.rx_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                r_tick_cnt <= '0;
    else if (!bus.en_i || w_tick)               r_tick_cnt <= '0;
    else                                        r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_data_sr  <= '0;
      r_par_bit  <= 1'b0;
      r_stop_idx <= 1'b0;
      r_size     <= 4'd8;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.en_i) begin
        r_state  <= S_IDLE;
        r_os_cnt <= '0;
      end else begin
        if (w_tick && r_os_cnt == OS_S0) r_s0 <= w_rx_s;
        if (w_tick && r_os_cnt == OS_S1) r_s1 <= w_rx_s;
        if (w_tick && r_state != S_IDLE && r_state != S_WAIT_HIGH)
          r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
        case (r_state)
          S_IDLE: if (w_tick && !w_rx_s) begin
            r_state    <= S_START;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_data_sr  <= '0;
            r_par_bit  <= 1'b0;
            r_stop_idx <= 1'b0;
            r_size     <= w_size;
            r_par_en   <= bus.parity_en_i;
            r_par_odd  <= bus.parity_odd_i;
            r_two_stop <= (bus.stop_size_i == 2'b10);
          end
          S_START: begin
            if (w_vote_tick && w_vote) begin
              r_state  <= S_IDLE;
              r_os_cnt <= '0;
            end else if (w_bit_end) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            if (w_vote_tick) r_data_sr[r_bit_cnt] <= w_vote;
            if (w_bit_end) begin
              if (r_bit_cnt == r_size - 4'd1) r_state <= r_par_en ? S_PARITY : S_STOP;
              else                            r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_PARITY: begin
            if (w_vote_tick) r_par_bit <= w_vote;
            if (w_bit_end)   r_state   <= S_STOP;
          end
          S_STOP: if (w_vote_tick) begin
            // Emit on the vote itself rather than bit end so an early next start is caught.
            if (r_two_stop && !r_stop_idx && w_vote) begin
              r_stop_idx <= 1'b1;
            end else begin
              r_data   <= r_data_sr;
              r_valid  <= 1'b1;
              r_perr   <= w_par_err;
              r_ferr   <= !w_vote;
              r_brk    <= !w_vote && (r_data_sr == 9'd0) && !r_par_bit;
              r_state  <= w_vote ? S_IDLE : S_WAIT_HIGH;
              r_os_cnt <= '0;
            end
          end
          S_WAIT_HIGH: if (w_rx_s) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign bus.parity_err_o = r_perr;
  assign bus.frame_err_o  = r_ferr;
  assign bus.break_o      = r_brk;
  assign bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: table of frames plus glitch, break,
// enable-abort and async-reset sequences; 64 clocks per bit.
module tb_uart_rx_frontend;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frontend_if #(.DIV_WIDTH(16)) bus_if ();

  uart_rx_frontend #(.OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus_if)
  );

  typedef struct {
    logic [3:0] size;
    logic       pen;
    logic       podd;
    logic [1:0] stop;
    logic [8:0] word;
    logic       pbit;
    logic [1:0] sv;
    int         nbits;
    int         nstop;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Output monitor: counts valid cycles, captures the frame, samples busy 5 clocks later.
  int         vcnt = 0;
  int         busy_cycles = 0;
  int         busy_cd = 0;
  logic       busy_cap = 1'b1;
  logic [8:0] cap_data = '0;
  logic       cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;
  always @(negedge clk) begin
    if (bus_if.busy_o) busy_cycles++;
    if (bus_if.valid_o) begin
      vcnt++;
      cap_data = bus_if.data_o;
      cap_perr = bus_if.parity_err_o;
      cap_ferr = bus_if.frame_err_o;
      cap_brk  = bus_if.break_o;
      busy_cd  = 5;
    end else if (busy_cd > 0) begin
      busy_cd--;
      if (busy_cd == 0) busy_cap = bus_if.busy_o;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus_if.rx_i = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int nbits, input logic [8:0] w, input logic pen,
                            input logic pbit, input int nstop, input logic [1:0] sv);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(w[i]);
    if (pen) drive_bit(pbit);
    for (int i = 0; i < nstop; i++) drive_bit(sv[i]);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int v0;
    bus_if.data_size_i  = v.size;
    bus_if.parity_en_i  = v.pen;
    bus_if.parity_odd_i = v.podd;
    bus_if.stop_size_i  = v.stop;
    v0 = vcnt;
    send_frame(v.nbits, v.word, v.pen, v.pbit, v.nstop, v.sv);
    chk({nm, "_nvalid"}, vcnt - v0, 1);
    chk({nm, "_data"}, cap_data, v.exp_data);
    chk({nm, "_perr"}, cap_perr, v.exp_perr);
    chk({nm, "_ferr"}, cap_ferr, v.exp_ferr);
    chk({nm, "_brk"}, cap_brk, v.exp_brk);
    if (!v.exp_ferr) chk({nm, "_busy_after"}, busy_cap, 0);
  endtask

  vec_t vt[10];
  vec_t vx;
  int   v0, b0;

  initial begin
    //          size  pen   podd  stop   word    pbit  sv     nb nst exp_data perr  ferr  brk
    vt[0] = '{4'd8,  1'b0, 1'b0, 2'b00, 9'h0A5, 1'b0, 2'b11, 8, 1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{4'd8,  1'b1, 1'b0, 2'b01, 9'h007, 1'b1, 2'b11, 8, 1, 9'h007, 1'b0, 1'b0, 1'b0};
    vt[2] = '{4'd8,  1'b1, 1'b0, 2'b01, 9'h007, 1'b0, 2'b11, 8, 1, 9'h007, 1'b1, 1'b0, 1'b0};
    vt[3] = '{4'd8,  1'b1, 1'b1, 2'b01, 9'h007, 1'b0, 2'b11, 8, 1, 9'h007, 1'b0, 1'b0, 1'b0};
    vt[4] = '{4'd7,  1'b0, 1'b0, 2'b10, 9'h055, 1'b0, 2'b01, 7, 2, 9'h055, 1'b0, 1'b1, 1'b0};
    vt[5] = '{4'd7,  1'b0, 1'b0, 2'b10, 9'h02A, 1'b0, 2'b11, 7, 2, 9'h02A, 1'b0, 1'b0, 1'b0};
    vt[6] = '{4'd3,  1'b0, 1'b0, 2'b11, 9'h015, 1'b0, 2'b11, 6, 1, 9'h015, 1'b0, 1'b0, 1'b0};
    vt[7] = '{4'd12, 1'b0, 1'b0, 2'b01, 9'h155, 1'b0, 2'b11, 9, 1, 9'h155, 1'b0, 1'b0, 1'b0};
    vt[8] = '{4'd9,  1'b1, 1'b1, 2'b01, 9'h1C3, 1'b1, 2'b11, 9, 1, 9'h1C3, 1'b1, 1'b0, 1'b0};
    vt[9] = '{4'd6,  1'b1, 1'b0, 2'b10, 9'h000, 1'b0, 2'b00, 6, 2, 9'h000, 1'b0, 1'b1, 1'b1};

    bus_if.en_i         = 1'b1;
    bus_if.baud_div_i   = 16'd3;
    bus_if.data_size_i  = 4'd8;
    bus_if.parity_en_i  = 1'b0;
    bus_if.parity_odd_i = 1'b0;
    bus_if.stop_size_i  = 2'b00;
    bus_if.rx_i         = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_data", bus_if.data_o, 0);
    chk("rst_valid", bus_if.valid_o, 0);
    chk("rst_perr", bus_if.parity_err_o, 0);
    chk("rst_ferr", bus_if.frame_err_o, 0);
    chk("rst_brk", bus_if.break_o, 0);
    chk("rst_busy", bus_if.busy_o, 0);
    rst_ni = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("idle_busy", bus_if.busy_o, 0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Short low glitch: false start, no frame.
    bus_if.data_size_i = 4'd8; bus_if.parity_en_i = 1'b0; bus_if.stop_size_i = 2'b00;
    v0 = vcnt; b0 = busy_cycles;
    bus_if.rx_i = 1'b0;
    repeat (16) @(negedge clk);
    bus_if.rx_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("glitch_busy_seen", (busy_cycles - b0) > 0, 1);
    chk("glitch_busy_end", bus_if.busy_o, 0);
    chk("glitch_nvalid", vcnt - v0, 0);
    vx = '{4'd8, 1'b0, 1'b0, 2'b00, 9'h03C, 1'b0, 2'b11, 8, 1, 9'h03C, 1'b0, 1'b0, 1'b0};
    run_vec(vx, "post_glitch");

    // Break: 12 bit times low yields exactly one frame.
    v0 = vcnt;
    bus_if.rx_i = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    chk("brk_nvalid", vcnt - v0, 1);
    chk("brk_data", cap_data, 0);
    chk("brk_ferr", cap_ferr, 1);
    chk("brk_flag", cap_brk, 1);
    chk("brk_busy_hold", bus_if.busy_o, 1);
    bus_if.rx_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("brk_nvalid_after", vcnt - v0, 1);
    vx = '{4'd8, 1'b0, 1'b0, 2'b00, 9'h081, 1'b0, 2'b11, 8, 1, 9'h081, 1'b0, 1'b0, 1'b0};
    run_vec(vx, "post_brk");

    // Enable dropped in data bit 3.
    v0 = vcnt;
    vx.word = 9'h05A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(vx.word[i]);
    bus_if.rx_i = vx.word[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("abort_busy_pre", bus_if.busy_o, 1);
    bus_if.en_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus_if.busy_o, 0);
    repeat (BIT_CLKS / 2 - 1) @(negedge clk);
    for (int i = 4; i < 8; i++) drive_bit(vx.word[i]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("abort_nvalid", vcnt - v0, 0);
    chk("abort_data_hold", bus_if.data_o, 9'h081);
    bus_if.en_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // Async reset mid-frame.
    drive_bit(1'b0);
    bus_if.rx_i = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("rstmid_busy_pre", bus_if.busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid_data", bus_if.data_o, 0);
    chk("rstmid_busy", bus_if.busy_o, 0);
    chk("rstmid_valid", bus_if.valid_o, 0);
    chk("rstmid_flags", {bus_if.parity_err_o, bus_if.frame_err_o, bus_if.break_o}, 0);
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vx = '{4'd8, 1'b0, 1'b0, 2'b00, 9'h0C3, 1'b0, 2'b11, 8, 1, 9'h0C3, 1'b0, 1'b0, 1'b0};
    run_vec(vx, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Oversampling UART receive front end. It synchronises the raw rx pin, generates its own oversample tick, and detects and validates the start bit. It majority-votes each bit, assembles frames of 6–9 data bits with optional parity and 1–2 stop bits, and emits one data word per frame with error flags. It sits directly upstream of the 9-bit rx FIFO in the UART subsystem: valid_o drives the FIFO write enable, and data_o drives the FIFO write data.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; even, >=8.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  1  receiver enable
baud_div_i  in  DIV_WIDTH  clk_i cycles per oversample tick, minus 1
data_size_i  in  4  data bits per frame; valid range 6..9
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop_size_i  in  2  stop bits; 2'b10 = two, any other value = one
rx_i  in  1  asynchronous serial line, idle high
data_o  out  9  received word, LSB = first data bit; unused upper bits are 0
valid_o  out  1  one-cycle pulse, new frame on data_o
parity_err_o  out  1  parity mismatch for the frame on data_o
frame_err_o  out  1  a stop bit was sampled as 0
break_o  out  1  all data, parity and stop bits were 0
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset and outputs:
  - Reset: rx synchroniser = 2'b11; all counters = 0; state = IDLE.
  - Reset: data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, break_o = 0, busy_o = 0.
  - Reset mid-frame aborts the frame with no output.
- Synchroniser: 2-flop chain gives rx_s. Detection latency is 2 clocks.
- Tick generator:
  - tick_cnt counts 0..baud_div_i. tick = (tick_cnt == baud_div_i), then tick_cnt wraps to 0.
  - baud_div_i = 0 gives a tick every cycle.
  - tick_cnt is held at 0 while en_i = 0.
- Bit timing:
  - os_cnt counts 0..OVERSAMPLE-1 on ticks. A bit ends on the tick where os_cnt = OVERSAMPLE-1.
  - Let M = OVERSAMPLE/2. rx_s is sampled on ticks with os_cnt = M-1, M and M+1.
  - The bit value is the 2-of-3 majority, taken on the os_cnt = M+1 tick.
- Configuration: data_size, parity and stop settings are latched on the IDLE->START transition and ignored mid-frame. data_size_i < 6 is treated as 6; data_size_i > 9 is treated as 9.
- FSM (all transitions occur on tick cycles unless stated):
  - IDLE: if rx_s == 0, go to START with os_cnt = 0.
  - START: if the vote is 1 (false start), return to IDLE with no output. Otherwise go to DATA at bit end, with bit_cnt = 0.
  - DATA: the vote is stored into data_sr[bit_cnt]. At bit end, if bit_cnt == size-1, go to PARITY when parity is enabled, else STOP. Otherwise increment bit_cnt.
  - PARITY: store the vote. Error if (XOR of data bits XOR parity bit) != parity_odd. Go to STOP at bit end.
  - STOP: on the vote, a 0 sets the frame error.
    - With two stop bits and the first stop vote 1, stay in STOP for the second bit.
    - The output is produced on the final stop-bit vote tick. Do not wait for bit end; this allows resync on an early next start.
    - After output, go to IDLE if the final stop vote is 1, else go to WAIT_HIGH.
    - With two stop bits, a 0 on the first stop vote ends the frame immediately: frame error is set and the output is produced.
  - WAIT_HIGH: go to IDLE on the first cycle with rx_s == 1 (tick not required). This prevents a break from generating repeated frames.
- Output timing:
  - data_o, the error flags and valid_o = 1 are registered the cycle after the output tick.
  - valid_o deasserts on the next cycle.
  - data_o and the flags hold until the next frame.
  - break_o = frame error AND data == 0 AND (parity bit == 0 or parity disabled).
- en_i = 0: the FSM goes to IDLE on the next clock and the frame in progress is discarded with no valid_o. Output registers keep their last values.
- The module applies no backpressure. FIFO-full handling belongs downstream.

Test Plan:
Common setup: baud_div_i = 3 and OVERSAMPLE = 16, giving 64 clocks per bit.
1. 8N1, send 0xA5 -> exactly one valid_o pulse; data_o = 0x0A5; parity_err_o = 0, frame_err_o = 0, break_o = 0; busy_o low within 1 tick after the output.
2. 8E1, send 0x07 with parity bit 1 -> parity_err_o = 0. Repeat with parity bit 0 -> parity_err_o = 1, data_o = 0x007. Then 8O1, send 0x07 with parity bit 0 -> parity_err_o = 0.
3. 7N2, send 0x55 with the second stop bit forced to 0 -> data_o = 0x055, frame_err_o = 1. The next frame, 0x2A, is received cleanly with frame_err_o = 0.
4. Glitch: rx_i low for 16 clocks (4 ticks), then high -> busy_o pulses and returns low; no valid_o. A following 0x3C frame is received correctly.
5. Break: rx_i low for 12 bit times at 8N1 -> one valid_o with data_o = 0, frame_err_o = 1, break_o = 1; no further valid_o until rx_i returns high; the next frame 0x81 is received correctly.
6. Abort: drop en_i during data bit 3 of a frame -> no valid_o, busy_o = 0 next clock. Then assert rst_ni low mid-frame -> all outputs go to 0 immediately.
